mem_arbiter: RTL

// - Shares one single-ported 64-bit memory between instruction fetch (IF) and load/store data (D).
// - Sits between the core's two memory ports and the memory model or the SRAM wrapper.
// - Grants one requester at a time and drives one outstanding memory transaction.
// - Routes the response back to the requester that owns the transaction.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arb_pick.sv | 42 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/D memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_AW = 64;
  localparam int unsigned MEM_DW = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  localparam logic [7:0] FETCH_BE = 8'hFF;

  // Select the 32-bit instruction half of a 64-bit memory word.
  function automatic logic [31:0] fetch_half(input logic upper, input logic [63:0] word);
    return upper ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the memory.
// slave: arbiter view. master: core + memory view (testbench side).
interface mem_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [DW/2-1:0] if_rdata_o;

  logic            d_req_i;
  logic            d_we_i;
  logic [7:0]      d_be_i;
  logic [AW-1:0]   d_addr_i;
  logic [DW-1:0]   d_wdata_i;
  logic            d_gnt_o;
  logic            d_rvalid_o;
  logic [DW-1:0]   d_rdata_o;

  logic            m_req_o;
  logic            m_we_o;
  logic [7:0]      m_be_o;
  logic [AW-1:0]   m_addr_o;
  logic [DW-1:0]   m_wdata_o;
  logic            m_gnt_i;
  logic            m_rvalid_i;
  logic [DW-1:0]   m_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
           m_gnt_i, m_rvalid_i, m_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
           m_gnt_i, m_rvalid_i, m_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Two-way combinational picker between fetch and data requesters.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on simultaneous requests);
// otherwise data always wins over fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  arb_owner_e last_owner_i,
  output logic       grant_if_o,
  output logic       grant_d_o
);

`ifdef MEM_ARB_RR_EN
  // On a tie the requester that did not own the last transaction wins.
  always_comb begin
    grant_if_o = 1'b0;
    grant_d_o  = 1'b0;
    if (if_req_i && d_req_i) begin
      if (last_owner_i == OWN_D) begin
        grant_if_o = 1'b1;
      end else begin
        grant_d_o = 1'b1;
      end
    end else begin
      grant_if_o = if_req_i;
      grant_d_o  = d_req_i;
    end
  end
`else
  // History is tracked by the top but plays no part in fixed priority.
  logic unused_last_owner_s;
  assign unused_last_owner_s = last_owner_i;

  // Fixed priority: data beats fetch.
  always_comb begin
    grant_d_o  = d_req_i;
    grant_if_o = if_req_i & ~d_req_i;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported 64-bit memory between instruction fetch and
// load/store data. One outstanding transaction; response routed to owner.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, last_owner_q;
  logic          addr2_q;
  logic          m_req_q;
  logic          m_we_q;
  logic [7:0]    m_be_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;

  logic          grant_if_s;
  logic          grant_d_s;
  logic          rsp_s;

  // Fetch address bits [1:0] are always ignored.
  logic unused_addr_s;
  assign unused_addr_s = ^bus.if_addr_i[1:0];

  mem_arb_pick u_pick (
    .if_req_i     (bus.if_req_i),
    .d_req_i      (bus.d_req_i),
    .last_owner_i (last_owner_q),
    .grant_if_o   (grant_if_s),
    .grant_d_o    (grant_d_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant in IDLE, wait for memory accept, then for the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_if_s || grant_d_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.m_gnt_i) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        if (bus.m_rvalid_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command/ownership registers: latch the winner's command at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      addr2_q      <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_be_q       <= 8'h00;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else if (state_q == ST_IDLE && grant_d_s) begin
      owner_q   <= OWN_D;
      m_req_q   <= 1'b1;
      m_we_q    <= bus.d_we_i;
      m_be_q    <= bus.d_be_i;
      m_addr_q  <= bus.d_addr_i;
      m_wdata_q <= bus.d_wdata_i;
    end else if (state_q == ST_IDLE && grant_if_s) begin
      owner_q   <= OWN_IF;
      addr2_q   <= bus.if_addr_i[2];
      m_req_q   <= 1'b1;
      m_we_q    <= 1'b0;
      m_be_q    <= FETCH_BE;
      m_addr_q  <= {bus.if_addr_i[AW-1:3], 3'b000};
      m_wdata_q <= '0;
    end else if (state_q == ST_REQ && bus.m_gnt_i) begin
      m_req_q <= 1'b0;
    end else if (state_q == ST_RESP && bus.m_rvalid_i) begin
      last_owner_q <= owner_q;
    end else begin
      m_req_q <= m_req_q;
    end
  end

  // Outputs: grants only in IDLE, responses only in RESP, both muted in reset.
  always_comb begin
    bus.if_gnt_o    = 1'b0;
    bus.d_gnt_o     = 1'b0;
    bus.if_rvalid_o = 1'b0;
    bus.d_rvalid_o  = 1'b0;
    bus.if_rdata_o  = '0;
    bus.d_rdata_o   = '0;
    rsp_s           = (state_q == ST_RESP) && bus.m_rvalid_i && !rst;
    if (state_q == ST_IDLE && !rst) begin
      bus.if_gnt_o = grant_if_s;
      bus.d_gnt_o  = grant_d_s;
    end else begin
      bus.if_gnt_o = 1'b0;
      bus.d_gnt_o  = 1'b0;
    end
    if (rsp_s && owner_q == OWN_IF) begin
      bus.if_rvalid_o = 1'b1;
      bus.if_rdata_o  = fetch_half(addr2_q, bus.m_rdata_i);
    end else if (rsp_s && owner_q == OWN_D) begin
      bus.d_rvalid_o = 1'b1;
      bus.d_rdata_o  = bus.m_rdata_i;
    end else begin
      bus.if_rvalid_o = 1'b0;
      bus.d_rvalid_o  = 1'b0;
    end
  end

  assign bus.m_req_o   = m_req_q;
  assign bus.m_we_o    = m_we_q;
  assign bus.m_be_o    = m_be_q;
  assign bus.m_addr_o  = m_addr_q;
  assign bus.m_wdata_o = m_wdata_q;

endmodule
